writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Merges the two producers of register-file writes into the single write port of `Registers`. The first producer is the in-order pipeline writeback, which has priority and never stalls. The second is the late-completion path for multi-cycle results (e.g. divide), which uses a valid/ready handshake and is buffered in a small FIFO. The block drives the register file's `RegWrite`/`RDaddr`/`RDdata` inputs and exports a per-register pending mask for the hazard unit.

## Interface
Parameters:
- `DEPTH`, 4 — late-write FIFO entries; power of two, ≥2.

Ports:
- `clk_i`  in  1  — clock; all state updates on posedge.
- `rst_i`  in  1  — asynchronous reset, active-low.
- `pipe_we_i`  in  1  — pipeline writeback valid.
- `pipe_rd_i`  in  5  — pipeline destination register.
- `pipe_data_i`  in  32  — pipeline write data.
- `late_valid_i`  in  1  — late-completion write offered.
- `late_rd_i`  in  5  — late destination register.
- `late_data_i`  in  32  — late write data.
- `late_ready_o`  out  1  — FIFO can accept a late write this cycle.
- `RegWrite_o`  out  1  — register-file write enable (registered).
- `RDaddr_o`  out  5  — register-file write address (registered).
- `RDdata_o`  out  32  — register-file write data (registered).
- `busy_o`  out  32  — bit r = 1 while a live queued write to xr is pending.

## Operation
- Effective pipeline write: `pipe_we_i && pipe_rd_i != 0`. Pipeline writes to x0 are ignored entirely.
- Late acceptance: `late_valid_i && late_ready_o` at posedge.
  - A late write to x0 is accepted and discarded (not enqueued).
- `late_ready_o = rst_i && (count < DEPTH)`.
  - It depends on occupancy only; a pop in the same cycle does not raise it.
- FIFO entry: {live, rd[4:0], data[31:0]}. Storage uses circular head/tail pointers of width log2(DEPTH) plus a count of width log2(DEPTH)+1.
- Kill rule (WAW ordering):
  - An effective pipeline write clears `live` on every FIFO entry whose rd equals `pipe_rd_i`.
  - A late write accepted in the same cycle with the same rd is discarded.
  - Rationale: queued late results are older in program order.
- Per-cycle selection, evaluated combinationally:
  1. If the effective pipeline write is present, it drives the output registers. The FIFO does not pop.
  2. Otherwise, if the FIFO is non-empty, the head pops.
     - Live head: drives the output registers.
     - Dead head (killed): popped silently; `RegWrite_o` = 0 next cycle.
  3. Otherwise `RegWrite_o` = 0 next cycle. `RDaddr_o`/`RDdata_o` hold their previous values.
- A head killed in the same cycle it would pop counts as dead.
- `busy_o`: OR over FIFO entries that are live and occupied, decoded by rd. Combinational from FIFO state; bit 0 is always 0.
- Push and pop in the same cycle: count is unchanged and both pointers advance.

## Timing
- Reset (rst_i low, asynchronous):
  - `RegWrite_o` = 0, `RDaddr_o` = 0, `RDdata_o` = 0.
  - FIFO empty: count = 0, pointers = 0, all live = 0.
  - `busy_o` = 0, `late_ready_o` = 0.
- Reset asserted mid-operation discards all queued writes; none reach the register file.
- Pipeline write latency: inputs sampled at edge N appear on `RegWrite_o`/`RDaddr_o`/`RDdata_o` after edge N, i.e. one cycle.
- Late write latency, minimum 2 cycles:
  - Accepted at edge N; enqueued after N.
  - Popped at edge N+1 if the pipeline is idle; output valid after N+1.
- There is no bypass from late input to output.
- Sustained pipeline writes starve the FIFO indefinitely.
  - When full, `late_ready_o` stays 0; the late producer must hold `late_valid_i` and its payload stable until accepted.
- `busy_o[r]` rises the cycle after acceptance. It falls the cycle after the entry pops or is killed.

## Test plan
- Pipeline write x5=0x1234 with no late traffic:
  - `RegWrite_o`=1, `RDaddr_o`=5, `RDdata_o`=0x1234 exactly one cycle later.
  - No output for `pipe_rd_i`=0.
- Late write x7=0xDEAD with the pipeline idle:
  - Accepted at edge N; output x7=0xDEAD after edge N+1.
  - `busy_o[7]`=1 for exactly one cycle.
- Fill FIFO with 4 late writes (x1..x4) while pipe_we_i=1 to x10 each cycle:
  - `late_ready_o`=0 after the 4th acceptance.
  - Drop pipe_we_i; outputs x1,x2,x3,x4 in order on consecutive cycles.
  - `late_ready_o` returns to 1 after the first pop.
- Queue late x9=0x1 behind busy pipeline cycles, then pipeline writes x9=0x2:
  - Output x9=0x2 only; the queued entry produces a `RegWrite_o`=0 bubble.
  - `busy_o[9]` clears the cycle after the kill.
- Same-cycle late acceptance and pipeline write, both rd=12:
  - Only the pipeline value is written.
  - `busy_o[12]` never asserts.
- Assert rst_i low with 3 queued entries:
  - All outputs 0 and `busy_o`=0 immediately.
  - After release, no queued write appears and `late_ready_o`=1.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Merges the in-order pipeline writeback with buffered late completions onto the
// single register-file write port and reports which registers still have queued writes.
module writeback_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pipe_we_i,
    input  logic [4:0]  pipe_rd_i,
    input  logic [31:0] pipe_data_i,
    input  logic        late_valid_i,
    input  logic [4:0]  late_rd_i,
    input  logic [31:0] late_data_i,
    output logic        late_ready_o,
    output logic        RegWrite_o,
    output logic [4:0]  RDaddr_o,
    output logic [31:0] RDdata_o,
    output logic [31:0] busy_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C  = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

    logic              r_live [DEPTH];
    logic [4:0]        r_rd   [DEPTH];
    logic [31:0]       r_data [DEPTH];
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [AW:0]       r_count;

    logic              r_regwrite;
    logic [4:0]        r_rdaddr;
    logic [31:0]       r_rddata;

    logic              w_pipe_eff;
    logic              w_ready;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_head_live;
    logic [31:0]       w_busy;

    assign w_pipe_eff  = pipe_we_i && (pipe_rd_i != 5'd0);
    assign w_ready     = rst_i && (r_count < DEPTH_C);
    assign w_accept    = late_valid_i && w_ready;
    // x0 writes and writes superseded by a same-cycle pipeline write to the same rd are dropped
    assign w_push      = w_accept && (late_rd_i != 5'd0) &&
                         !(w_pipe_eff && (late_rd_i == pipe_rd_i));
    assign w_pop       = !w_pipe_eff && (r_count != {(AW+1){1'b0}});
    assign w_head_live = r_live[r_head];

    // Pending-write mask decoded from live entries (live implies occupied)
    always_comb begin
        w_busy = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i]) begin
                w_busy[r_rd[i]] = 1'b1;
            end else begin
                w_busy = w_busy;
            end
        end
        w_busy[0] = 1'b0;
    end

    // FIFO storage, liveness and pointer/count maintenance
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_head  <= {AW{1'b0}};
            r_tail  <= {AW{1'b0}};
            r_count <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_live[i] <= 1'b0;
                r_rd[i]   <= 5'd0;
                r_data[i] <= 32'd0;
            end
        end else begin
            // Queued late results are older than the pipeline write, so it supersedes them
            for (int i = 0; i < DEPTH; i++) begin
                if (w_pipe_eff && (r_rd[i] == pipe_rd_i)) begin
                    r_live[i] <= 1'b0;
                end
            end
            if (w_pop) begin
                r_live[r_head] <= 1'b0;
                r_head         <= r_head + PTR_ONE;
            end
            // Push last so a stale rd in the free tail slot cannot kill the new entry
            if (w_push) begin
                r_live[r_tail] <= 1'b1;
                r_rd[r_tail]   <= late_rd_i;
                r_data[r_tail] <= late_data_i;
                r_tail         <= r_tail + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_ONE;
            end else begin
                r_count <= r_count;
            end
        end
    end

    // Register-file write port: pipeline first, then live FIFO head
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_regwrite <= 1'b0;
            r_rdaddr   <= 5'd0;
            r_rddata   <= 32'd0;
        end else if (w_pipe_eff) begin
            r_regwrite <= 1'b1;
            r_rdaddr   <= pipe_rd_i;
            r_rddata   <= pipe_data_i;
        end else if (w_pop && w_head_live) begin
            r_regwrite <= 1'b1;
            r_rdaddr   <= r_rd[r_head];
            r_rddata   <= r_data[r_head];
        end else begin
            r_regwrite <= 1'b0;
        end
    end

    assign late_ready_o = w_ready;
    assign RegWrite_o   = r_regwrite;
    assign RDaddr_o     = r_rdaddr;
    assign RDdata_o     = r_rddata;
    assign busy_o       = w_busy;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter with hand-computed expectations.
module tb_writeback_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pipe_we_i;
    logic [4:0]  pipe_rd_i;
    logic [31:0] pipe_data_i;
    logic        late_valid_i;
    logic [4:0]  late_rd_i;
    logic [31:0] late_data_i;
    logic        late_ready_o;
    logic        RegWrite_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;
    logic [31:0] busy_o;

    int n_pass  = 0;
    int n_total = 0;

    writeback_arbiter #(.DEPTH(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pipe_we_i    (pipe_we_i),
        .pipe_rd_i    (pipe_rd_i),
        .pipe_data_i  (pipe_data_i),
        .late_valid_i (late_valid_i),
        .late_rd_i    (late_rd_i),
        .late_data_i  (late_data_i),
        .late_ready_o (late_ready_o),
        .RegWrite_o   (RegWrite_o),
        .RDaddr_o     (RDaddr_o),
        .RDdata_o     (RDdata_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic we, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, ".we"},   {31'd0, RegWrite_o}, {31'd0, we});
        chk({tag, ".addr"}, {27'd0, RDaddr_o},   {27'd0, rd});
        chk({tag, ".data"}, RDdata_o, d);
    endtask

    initial begin
        rst_i = 1'b0; pipe_we_i = 1'b0; pipe_rd_i = 5'd0; pipe_data_i = 32'd0;
        late_valid_i = 1'b0; late_rd_i = 5'd0; late_data_i = 32'd0;
        #12;
        chk_out("reset", 1'b0, 5'd0, 32'd0);
        chk("reset.busy",  busy_o, 32'd0);
        chk("reset.ready", {31'd0, late_ready_o}, 32'd0);
        rst_i = 1'b1;
        #1;
        chk("post_reset.ready", {31'd0, late_ready_o}, 32'd1);

        // Pipeline write x5 and ignored write to x0
        pipe_we_i = 1'b1; pipe_rd_i = 5'd5; pipe_data_i = 32'h0000_1234;
        tick();
        chk_out("pipe_x5", 1'b1, 5'd5, 32'h0000_1234);
        pipe_rd_i = 5'd0; pipe_data_i = 32'h0000_FFFF;
        tick();
        chk_out("pipe_x0", 1'b0, 5'd5, 32'h0000_1234);
        pipe_we_i = 1'b0;

        // Late write x7 with idle pipeline: two-cycle latency
        late_valid_i = 1'b1; late_rd_i = 5'd7; late_data_i = 32'h0000_DEAD;
        tick();
        late_valid_i = 1'b0;
        chk("late_x7.no_bypass", {31'd0, RegWrite_o}, 32'd0);
        chk("late_x7.busy1", busy_o, 32'h0000_0080);
        tick();
        chk_out("late_x7.out", 1'b1, 5'd7, 32'h0000_DEAD);
        chk("late_x7.busy0", busy_o, 32'd0);

        // Fill FIFO behind continuous pipeline writes to x10
        for (int i = 1; i <= 4; i++) begin
            pipe_we_i = 1'b1; pipe_rd_i = 5'd10; pipe_data_i = 32'h100 + i;
            late_valid_i = 1'b1; late_rd_i = i[4:0]; late_data_i = 32'h10 * i;
            chk("fill.ready", {31'd0, late_ready_o}, 32'd1);
            tick();
        end
        late_valid_i = 1'b0;
        chk("fill.full_ready", {31'd0, late_ready_o}, 32'd0);
        chk("fill.busy", busy_o, 32'h0000_001E);
        chk_out("fill.pipe", 1'b1, 5'd10, 32'h0000_0104);
        pipe_we_i = 1'b0;
        tick();
        chk_out("drain1", 1'b1, 5'd1, 32'h0000_0010);
        chk("drain1.ready", {31'd0, late_ready_o}, 32'd1);
        tick();
        chk_out("drain2", 1'b1, 5'd2, 32'h0000_0020);
        tick();
        chk_out("drain3", 1'b1, 5'd3, 32'h0000_0030);
        tick();
        chk_out("drain4", 1'b1, 5'd4, 32'h0000_0040);
        tick();
        chk("drain.idle", {31'd0, RegWrite_o}, 32'd0);
        chk("drain.busy", busy_o, 32'd0);

        // Queued x9 killed by later pipeline write to x9
        pipe_we_i = 1'b1; pipe_rd_i = 5'd10; pipe_data_i = 32'h0000_00AA;
        late_valid_i = 1'b1; late_rd_i = 5'd9; late_data_i = 32'h0000_0001;
        tick();
        late_valid_i = 1'b0;
        chk("kill.busy1", busy_o, 32'h0000_0200);
        pipe_rd_i = 5'd9; pipe_data_i = 32'h0000_0002;
        tick();
        pipe_we_i = 1'b0;
        chk_out("kill.pipe", 1'b1, 5'd9, 32'h0000_0002);
        chk("kill.busy0", busy_o, 32'd0);
        tick();
        chk_out("kill.bubble", 1'b0, 5'd9, 32'h0000_0002);
        tick();
        chk("kill.idle", {31'd0, RegWrite_o}, 32'd0);

        // Same-cycle pipeline and late write to x12
        pipe_we_i = 1'b1; pipe_rd_i = 5'd12; pipe_data_i = 32'h0000_0055;
        late_valid_i = 1'b1; late_rd_i = 5'd12; late_data_i = 32'h0000_0066;
        tick();
        pipe_we_i = 1'b0; late_valid_i = 1'b0;
        chk_out("same.pipe", 1'b1, 5'd12, 32'h0000_0055);
        chk("same.busy", busy_o, 32'd0);
        tick();
        chk("same.no_late", {31'd0, RegWrite_o}, 32'd0);
        chk("same.busy2", busy_o, 32'd0);

        // Reset with three queued entries
        for (int i = 0; i < 3; i++) begin
            pipe_we_i = 1'b1; pipe_rd_i = 5'd10; pipe_data_i = 32'h200 + i;
            late_valid_i = 1'b1; late_rd_i = 5'd20 + i[4:0]; late_data_i = 32'h300 + i;
            tick();
        end
        pipe_we_i = 1'b0; late_valid_i = 1'b0;
        chk("rst.busy_before", busy_o, 32'h0070_0000);
        #2;
        rst_i = 1'b0;
        #1;
        chk_out("rst.async", 1'b0, 5'd0, 32'd0);
        chk("rst.busy", busy_o, 32'd0);
        chk("rst.ready", {31'd0, late_ready_o}, 32'd0);
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        chk("rst.after_we", {31'd0, RegWrite_o}, 32'd0);
        chk("rst.after_ready", {31'd0, late_ready_o}, 32'd1);
        chk("rst.after_busy", busy_o, 32'd0);
        tick();
        chk("rst.after_we2", {31'd0, RegWrite_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
